// File: rtl/fwrisc_mem_pkg.sv
// Shared encodings, tracking-entry layout and access-rule helpers for the
// fwrisc memory pipe.
package fwrisc_mem_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10
    } mem_op_e;

    // One entry per accepted request, retired strictly in issue order.
    typedef struct packed {
        logic [3:0] op;
        logic [1:0] off;
        logic       err;
    } trk_ent_t;

    localparam int TRK_W = $bits(trk_ent_t);

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
        logic m;
        m = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: m = off[0];
            OP_LW, OP_SW:         m = (off != 2'b00);
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

    // Picks the addressed lane out of the bus word and extends it; stores yield 0.
    function automatic logic [31:0] load_extend(input logic [3:0]  op,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [31:0] lane;
        logic [31:0] r;
        lane = word >> {off, 3'b000};
        case (op)
            OP_LB:   r = {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  r = {24'h0, lane[7:0]};
            OP_LH:   r = {{16{lane[15]}}, lane[15:0]};
            OP_LHU:  r = {16'h0, lane[15:0]};
            OP_LW:   r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fwrisc_mem_fifo.sv
// In-order tracking FIFO for outstanding memory requests.
// Latency: pushed entry is visible at head_dat the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; full/count steer the producer.
module fwrisc_mem_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_rdy && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fwrisc_mem_pipe.sv
// Core-to-bus load/store pipe with in-order completion and misalignment trapping.
// Latency: load accept to ack_valid is 3 cycles minimum; misaligned entries ack 1 cycle after reaching head.
// Backpressure: req_ready drops when DEPTH requests are outstanding or the bus request is stalled.
module fwrisc_mem_pipe
    import fwrisc_mem_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_data,
    output logic        ack_valid,
    output logic [31:0] ack_data,
    output logic        ack_err,
    output logic        dvalid,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwstb,
    output logic        dwrite,
    input  logic        dready,
    input  logic        drvalid,
    input  logic [31:0] drdata
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    trk_ent_t         push_ent;
    trk_ent_t         head_ent;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             req_fire;
    logic             req_err;
    logic             err_pop;
    logic             rsp_pop;
    logic             head_pop;
    logic [3:0]       lane_stb;
    logic [31:0]      lane_dat;
    logic             is_store;

    // Gating with reset keeps the core from seeing a ready while held in reset.
    assign req_ready = reset && !fifo_full && (fifo_count < CNT_W'(DEPTH))
                       && (!dvalid || dready);
    assign req_fire  = req_valid && req_ready;
    assign req_err   = CHECK_ALIGN && misaligned(req_op, req_addr[1:0]);

    assign push_ent.op  = req_op;
    assign push_ent.off = req_addr[1:0];
    assign push_ent.err = req_err;

    // Trapped entries never reach the bus, so drvalid cannot belong to them.
    assign err_pop  = !fifo_empty && head_ent.err;
    assign rsp_pop  = !fifo_empty && !head_ent.err && drvalid;
    assign head_pop = err_pop || rsp_pop;

    always_comb begin
        lane_stb = '0;
        lane_dat = '0;
        is_store = 1'b0;
        case (req_op)
            OP_SB: begin
                is_store = 1'b1;
                lane_stb = 4'b0001 << req_addr[1:0];
                lane_dat = {4{req_data[7:0]}};
            end
            OP_SH: begin
                is_store = 1'b1;
                lane_stb = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{req_data[15:0]}};
            end
            OP_SW: begin
                is_store = 1'b1;
                lane_stb = 4'b1111;
                lane_dat = req_data;
            end
            default: ;
        endcase
    end

    fwrisc_mem_fifo #(
        .WIDTH (TRK_W),
        .DEPTH (DEPTH)
    ) u_trk_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (req_fire),
        .push_dat (push_ent),
        .pop_rdy  (head_pop),
        .head_dat (head_ent),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dvalid <= 1'b0;
            daddr  <= '0;
            dwdata <= '0;
            dwstb  <= '0;
            dwrite <= 1'b0;
        end else if (req_fire && !req_err) begin
            dvalid <= 1'b1;
            daddr  <= {req_addr[31:2], 2'b00};
            dwdata <= lane_dat;
            dwstb  <= lane_stb;
            dwrite <= is_store;
        end else if (dready) begin
            dvalid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_valid <= 1'b0;
            ack_err   <= 1'b0;
            ack_data  <= '0;
        end else begin
            ack_valid <= head_pop;
            ack_err   <= err_pop;
            ack_data  <= rsp_pop ? load_extend(head_ent.op, head_ent.off, drdata) : '0;
        end
    end

endmodule

// File: doc/fwrisc_mem_pipe.md
FWRISC_MEM_PIPE -- requirements
Module: fwrisc_mem_pipe

Interface
REQ-001 Parameter DEPTH, default 2, is the maximum number of outstanding bus transactions; legal values are powers of two from 1 to 16.
REQ-002 Parameter CHECK_ALIGN, default 1, enables misaligned-access trapping when set to 1.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  core request valid.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_op  in  4  memory op (package encoding).
REQ-010 req_data  in  32  store data, right-aligned.
REQ-011 ack_valid  out  1  one-cycle completion pulse.
REQ-012 ack_data  out  32  extended load data; 0 for stores and errors.
REQ-013 ack_err  out  1  misaligned access, qualified by ack_valid.
REQ-014 dvalid, daddr[32], dwdata[32], dwstb[4], dwrite  out  bus request channel.
REQ-015 dready  in  1  bus request accepted when dvalid && dready.
REQ-016 drvalid  in  1  bus response valid; one per accepted request, in order.
REQ-017 drdata  in  32  bus read data.

Function
REQ-018 req_ready SHALL be (count < DEPTH) && (!dvalid || dready), where count is the number of tracked entries.
REQ-019 An accepted aligned request SHALL drive a registered bus request the next cycle, held until dready.
- daddr = {req_addr[31:2],2'b00}.
- dwrite set for SB/SH/SW.
- dwstb/dwdata: SB uses a byte-lane strobe and {4{data[7:0]}}; SH uses 0011/1100 and {2{data[15:0]}}; SW uses 1111 and the full word; loads use 0000 and 0.
REQ-020 Every accepted request SHALL push {op, addr[1:0], err} into an in-order tracking FIFO; a pop occurs when the head entry is acknowledged.
REQ-021 Misalignment (CHECK_ALIGN=1) is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- No bus request is issued.
- The entry is acknowledged with ack_err=1 and ack_data=0 on the cycle after it reaches the FIFO head.
REQ-022 On drvalid with a non-error head entry, ack_valid SHALL assert the next cycle.
- ack_data is selected from drdata by the stored op and addr[1:0].
- LB/LH are sign-extended; LBU/LHU are zero-extended; LW passes the word through.
REQ-023 drvalid with an empty FIFO or an error head entry SHALL be ignored.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged.
- Accepting while count==DEPTH is impossible by REQ-018.
- Pointers wrap modulo DEPTH.
REQ-025 Minimum load latency (req accept to ack_valid) with dready=1 and drvalid in the cycle after bus accept is 3 cycles.
- Back-to-back accepts SHALL sustain one request per cycle while the FIFO is not full.

Reset
REQ-026 While reset=0, all outputs and internal state SHALL clear asynchronously.
- ack_valid, ack_err, ack_data, dvalid, daddr, dwdata, dwstb and dwrite go to 0.
- FIFO pointers and count go to 0.
- req_ready is 0 during reset and 1 on the first cycle after release.
REQ-027 Reset mid-transaction SHALL discard all outstanding entries; late drvalid after release is ignored per REQ-023.

Structure
REQ-028 Package fwrisc_mem_pkg SHALL hold the op encodings: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=8, SH=9, SW=10.
REQ-029 The package SHALL also hold the tracking-entry struct and the misalignment function.
REQ-030 The tracking FIFO SHALL be sub-module fwrisc_mem_fifo, parameterised by WIDTH and DEPTH, and SHALL provide full/empty/count outputs.

Verification
REQ-031 LB addr=0x103, drdata=0x80FF_FFFF -> ack_data=0xFFFF_FF80, ack_err=0.
REQ-032 SH addr=0x202, data=0x1234ABCD -> dwstb=1100, dwdata=0xABCDABCD, dwrite=1; ack_data=0 after drvalid.
REQ-033 DEPTH=2, three LW requests, drvalid withheld -> req_ready=0 after two accepts; it rises the cycle after the first drvalid, and acks arrive in issue order.
REQ-034 LW addr=0x6, then LW addr=0x8 -> no bus request for 0x6; ack_err=1 first, then 0x8 data with ack_err=0.
REQ-035 reset=0 asserted with two loads outstanding -> all outputs 0 immediately; post-release drvalid produces no ack_valid.
REQ-036 Simultaneous push and pop at count=DEPTH-1, repeated 20 times -> count stable and pointers wrap, with no lost or duplicated ack.
